// File: rtl/hdlc_tx_framer.sv
// rtl/hdlc_tx_framer.sv - HDLC transmit framer: flags, zero stuffing, abort and idle generation
module hdlc_tx_framer #(
  parameter int STUFF_LIMIT = 5,
  parameter int ABORT_ONES  = 7
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TxEN,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  input  logic       Tx_Last,
  output logic       Tx_Ready,
  input  logic       Tx_AbortReq,
  output logic       Tx,
  output logic       Tx_FrameActive,
  output logic       Tx_Done,
  output logic       Tx_AbortedFrame,
  output logic       Tx_Underrun
);

  localparam int CW = $clog2(ABORT_ONES + 9);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [7:0]    FLAG      = 8'h7E;
  localparam logic [CW-1:0] LAST_BIT  = CW'(7);
  localparam logic [CW-1:0] ABORT_END = CW'(ABORT_ONES);
  localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);

  // state names describe the bit currently on Tx
  typedef enum logic [2:0] {
    S_IDLE, S_FLAG_OPEN, S_DATA, S_STUFF, S_FLAG_CLOSE, S_ABORT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [OW-1:0] ones;
  logic [7:0]    shift, hold;
  logic          hold_full, hold_last, cur_last, last_seen;
  logic          accept, abort_evt, load, adv, under, tx_nx;

  assign Tx_Ready  = Rst && TxEN && !hold_full && !last_seen &&
                     (state == S_IDLE || state == S_FLAG_OPEN || state == S_DATA);
  assign accept    = Tx_Valid && Tx_Ready;
  assign abort_evt = (Tx_AbortReq || !TxEN) && state != S_IDLE && state != S_ABORT;

  // state register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next-state: a stuff check comes before any byte-end decision, abort overrides everything
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    adv      = 1'b0;
    under    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_FLAG_OPEN;
          cnt_nx   = '0;
        end
      end
      S_FLAG_OPEN: begin
        if (cnt == LAST_BIT) begin
          state_nx = S_DATA;
          cnt_nx   = '0;
          load     = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DATA, S_STUFF: begin
        if (state == S_DATA && ones == ONES_MAX) begin
          state_nx = S_STUFF;
        end else if (cnt != LAST_BIT) begin
          state_nx = S_DATA;
          cnt_nx   = cnt + 1'b1;
          adv      = 1'b1;
        end else if (cur_last) begin
          state_nx = S_FLAG_CLOSE;
          cnt_nx   = '0;
        end else if (hold_full) begin
          state_nx = S_DATA;
          cnt_nx   = '0;
          load     = 1'b1;
        end else begin
          state_nx = S_ABORT;
          cnt_nx   = '0;
          under    = 1'b1;
        end
      end
      S_FLAG_CLOSE: begin
        if (cnt == LAST_BIT) state_nx = S_IDLE;
        else                 cnt_nx   = cnt + 1'b1;
      end
      S_ABORT: begin
        if (cnt == ABORT_END) state_nx = S_IDLE;
        else                  cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort_evt) begin
      state_nx = S_ABORT;
      cnt_nx   = '0;
      load     = 1'b0;
      adv      = 1'b0;
    end
  end

  // output: the bit that goes onto Tx at the next edge
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      S_FLAG_OPEN, S_FLAG_CLOSE: tx_nx = FLAG[cnt_nx[2:0]];
      S_DATA:                    tx_nx = load ? hold[0] : shift[1];
      S_STUFF:                   tx_nx = 1'b0;
      S_ABORT:                   tx_nx = (cnt_nx != '0);
      default:                   tx_nx = 1'b1;
    endcase
  end

  // registered line and status pulses
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Tx              <= 1'b1;
      Tx_FrameActive  <= 1'b0;
      Tx_Done         <= 1'b0;
      Tx_AbortedFrame <= 1'b0;
      Tx_Underrun     <= 1'b0;
    end else begin
      Tx              <= tx_nx;
      Tx_FrameActive  <= (state_nx != S_IDLE);
      Tx_Done         <= (state == S_FLAG_CLOSE) && (state_nx == S_IDLE);
      Tx_AbortedFrame <= (state == S_ABORT) && (state_nx == S_IDLE);
      Tx_Underrun     <= under;
    end
  end

  // datapath: hold register, shift register and consecutive-ones counter
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      cur_last  <= 1'b0;
      last_seen <= 1'b0;
      ones      <= '0;
    end else begin
      if (load) begin
        shift    <= hold;
        cur_last <= hold_last;
      end else if (adv) begin
        shift <= {1'b0, shift[7:1]};
      end
      if (state_nx == S_DATA) ones <= tx_nx ? ones + 1'b1 : '0;
      else                    ones <= '0;
      if (abort_evt || state_nx == S_IDLE) begin
        hold_full <= 1'b0;
        hold_last <= 1'b0;
        last_seen <= 1'b0;
      end else if (accept) begin
        hold      <= Tx_Data;
        hold_full <= 1'b1;
        hold_last <= Tx_Last;
        if (Tx_Last) last_seen <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb/tb_hdlc_tx_framer.sv - randomized self-checking bench for hdlc_tx_framer
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst, TxEN, Tx_Valid, Tx_Last, Tx_AbortReq;
  logic [7:0] Tx_Data;
  logic       Tx_Ready, Tx, Tx_FrameActive, Tx_Done, Tx_AbortedFrame, Tx_Underrun;

  always #5 Clk = ~Clk;

  hdlc_tx_framer dut (
    .Clk(Clk), .Rst(Rst), .TxEN(TxEN), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid),
    .Tx_Last(Tx_Last), .Tx_Ready(Tx_Ready), .Tx_AbortReq(Tx_AbortReq), .Tx(Tx),
    .Tx_FrameActive(Tx_FrameActive), .Tx_Done(Tx_Done),
    .Tx_AbortedFrame(Tx_AbortedFrame), .Tx_Underrun(Tx_Underrun)
  );

  // expected line contents, one entry per cycle; kind 0 idle, 1 frame bit, 2 abort bit
  typedef struct {
    logic tx; logic act; logic dn; logic ab; logic ur; int kind;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cur_kind = 0;
  bit   chk = 0;
  int   m_ones;

  localparam int NFR = 70;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic tx, input logic act, input logic dn,
                               input logic ab, input logic ur, input int kind);
    exp_t e;
    e.tx = tx; e.act = act; e.dn = dn; e.ab = ab; e.ur = ur; e.kind = kind;
    q.push_back(e);
  endfunction

  function automatic void push_flag();
    logic [7:0] fl = 8'b01111110;
    for (int i = 7; i >= 0; i--) push(fl[i], 1'b1, 1'b0, 1'b0, 1'b0, 1);
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      push(b[i], 1'b1, 1'b0, 1'b0, 1'b0, 1);
      m_ones = b[i] ? m_ones + 1 : 0;
      if (m_ones == 5) begin
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        m_ones = 0;
      end
    end
  endfunction

  function automatic void push_close();
    push_flag();
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
  endfunction

  function automatic void push_abort(input logic ur);
    push(1'b0, 1'b1, 1'b0, 1'b0, ur, 2);
    for (int i = 0; i < 7; i++) push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
  endfunction

  // per-cycle comparison against the model queue
  always @(negedge Clk) begin
    if (chk) begin
      exp_t e;
      if (q.size() > 0) e = q.pop_front();
      else begin
        e.tx = 1'b1; e.act = 1'b0; e.dn = 1'b0; e.ab = 1'b0; e.ur = 1'b0; e.kind = 0;
      end
      cur_kind = e.kind;
      vectors++;
      if ({Tx, Tx_FrameActive, Tx_Done, Tx_AbortedFrame, Tx_Underrun} !==
          {e.tx, e.act, e.dn, e.ab, e.ur}) begin
        miscompares++;
        $display("FAIL line @%0t: tx/act/done/abt/ur got %b expected %b", $time,
                 {Tx, Tx_FrameActive, Tx_Done, Tx_AbortedFrame, Tx_Underrun},
                 {e.tx, e.act, e.dn, e.ab, e.ur});
      end
      if (e.kind == 0) begin
        vectors++;
        if (Tx_Ready !== TxEN) begin
          miscompares++;
          $display("FAIL ready_idle @%0t: got %b expected %b", $time, Tx_Ready, TxEN);
        end
      end
    end
  end

  logic [7:0]  d [4];
  int          n, idx, abort_at, gap, cyc, fr, ak;
  bit          ur_frame, coin, started, sending, aborted, u;
  logic        xfer;
  logic [63:0] bits;

  function automatic logic [7:0] pick_byte();
    case ($urandom % 6)
      0:       return 8'hFF;
      1:       return 8'h7E;
      2:       return 8'h1F;
      3:       return 8'hF8;
      default: return 8'($urandom);
    endcase
  endfunction

  task new_frame();
    ur_frame = 0; ak = 0; abort_at = 0; coin = 0; gap = 0;
    case (fr)
      0: begin n = 1; d[0] = 8'h00; end
      1: begin n = 1; d[0] = 8'hFF; end
      2: begin n = 1; d[0] = 8'h7E; end
      3: begin n = 1; d[0] = 8'h55; ur_frame = 1; gap = 2; end
      4: begin n = 3; for (int i = 0; i < 3; i++) d[i] = pick_byte(); ak = 1; abort_at = 20; gap = 1; end
      5: begin n = 3; for (int i = 0; i < 3; i++) d[i] = pick_byte(); ak = 2; abort_at = 22; gap = 1; end
      default: begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < 4; i++) d[i] = pick_byte();
        ur_frame = ($urandom % 4 == 0);
        ak       = ($urandom % 4 == 0) ? 0 : int'($urandom % 3);
        abort_at = $urandom_range(1, 60);
        coin     = $urandom % 2;
        gap      = $urandom_range(0, 3);
      end
    endcase
    idx = 0; started = 0; sending = 1; aborted = 0; cyc = 0;
  endtask

  task pin_model();
    bits = '0;
    foreach (q[i]) bits = {bits[62:0], q[i].tx};
    case (fr)
      0: begin
        check("pin_00_len", 64'(q.size()), 64'd25);
        check("pin_00_bits", bits, 64'(25'b0111111000000000011111101));
        check("pin_00_done", 64'(q[24].dn), 64'd1);
      end
      1: begin
        check("pin_ff_len", 64'(q.size()), 64'd26);
        check("pin_ff_bits", bits, 64'(26'b01111110111110111011111101));
      end
      2: begin
        check("pin_7e_len", 64'(q.size()), 64'd26);
        check("pin_7e_bits", bits, 64'(26'b01111110011111010011111101));
      end
      3: begin
        check("pin_55_len", 64'(q.size()), 64'd25);
        check("pin_55_bits", bits, 64'(25'b0111111010101010011111111));
        check("pin_55_ur", 64'(q[16].ur), 64'd1);
        check("pin_55_abt", 64'(q[24].ab), 64'd1);
      end
      default: ;
    endcase
  endtask

  initial begin
    Rst = 1'b0; TxEN = 1'b1; Tx_Valid = 1'b0; Tx_Data = '0; Tx_Last = 1'b0; Tx_AbortReq = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_tx", 64'(Tx), 64'd1);
    check("reset_ready", 64'(Tx_Ready), 64'd0);
    check("reset_active", 64'(Tx_FrameActive), 64'd0);
    check("reset_pulses", 64'({Tx_Done, Tx_AbortedFrame, Tx_Underrun}), 64'd0);
    #1;
    TxEN = 1'b0;
    Rst  = 1'b1;
    chk  = 1;
    repeat (50) @(negedge Clk);
    #1 TxEN = 1'b1;
    repeat (10) @(negedge Clk);

    fr = 0;
    new_frame();
    for (int it = 0; it < 30000 && fr < NFR; it++) begin
      @(negedge Clk);
      #1;
      if (started && q.size() == 0) begin
        fr++;
        if (fr == NFR) break;
        new_frame();
        if (TxEN == 1'b0 && gap < 3) gap = 3;
      end
      if (gap > 0) begin
        gap--;
        Tx_Valid    = 1'b0;
        Tx_Last     = 1'b0;
        Tx_AbortReq = ($urandom % 6 == 0);
      end else begin
        if (!(aborted && ak == 2)) TxEN = 1'b1;
        if (ak != 0 && !aborted && started && cur_kind == 1 &&
            (cyc >= abort_at || (coin && ur_frame && q.size() > 0 && q[0].ur))) begin
          u = (q.size() > 0) && q[0].ur;
          q.delete();
          push_abort(u);
          if (ak == 1) Tx_AbortReq = 1'b1;
          else         TxEN = 1'b0;
          aborted = 1;
          sending = 0;
        end else begin
          Tx_AbortReq = 1'b0;
        end
        if (sending && idx < n) begin
          Tx_Valid = 1'b1;
          Tx_Data  = d[idx];
          Tx_Last  = !ur_frame && (idx == n - 1);
        end else begin
          Tx_Valid = 1'b0;
          Tx_Last  = 1'b0;
        end
      end
      #1 xfer = Tx_Valid && Tx_Ready;
      @(posedge Clk);
      if (xfer) begin
        if (idx == 0) begin
          m_ones = 0;
          push_flag();
          started = 1;
        end
        push_byte(d[idx]);
        idx++;
        if (idx == n) begin
          if (ur_frame) push_abort(1'b1);
          else          push_close();
          if (fr < 4) pin_model();
        end
      end
      cyc++;
      if (cyc > 600) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_timeout: frame %0d not finished after %0d cycles", fr, cyc);
        break;
      end
    end

    // reset in the middle of a frame drops it without an abort pattern
    @(negedge Clk);
    #1;
    chk = 0;
    q.delete();
    TxEN = 1'b1; Tx_AbortReq = 1'b0;
    Tx_Valid = 1'b1; Tx_Data = 8'hFF; Tx_Last = 1'b1;
    @(posedge Clk);
    #1 Tx_Valid = 1'b0; Tx_Last = 1'b0;
    repeat (12) @(posedge Clk);
    #2;
    check("mid_active_before", 64'(Tx_FrameActive), 64'd1);
    Rst = 1'b0;
    #1;
    check("mid_reset_tx", 64'(Tx), 64'd1);
    check("mid_reset_active", 64'(Tx_FrameActive), 64'd0);
    check("mid_reset_ready", 64'(Tx_Ready), 64'd0);
    @(negedge Clk);
    #1 Rst = 1'b1;
    chk = 1;
    repeat (20) @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
Serial HDLC transmit framer and the counterpart of the Rx path. It accepts payload bytes over a valid/ready handshake and sends one bit per Clk on Tx. Each frame is sent as opening flag, zero-stuffed payload, then closing flag. The block emits the all-ones idle pattern when no frame is active, and generates abort sequences on request, on TxEN loss, or on data underrun.

Parameters:
STUFF_LIMIT, 5, number of consecutive payload 1s after which a 0 is inserted
ABORT_ONES, 7, number of 1s sent after the leading 0 of an abort sequence

Ports:
Clk  input  1  system clock; all state updates on rising edge
Rst  input  1  reset, asynchronous, active-low
TxEN  input  1  transmit enable; low forces idle or abort
Tx_Data  input  8  payload byte, sent LSB first
Tx_Valid  input  1  Tx_Data/Tx_Last valid
Tx_Last  input  1  qualifies the byte as the final payload byte of the frame
Tx_Ready  output  1  block accepts the byte this cycle
Tx_AbortReq  input  1  request abort of the current frame
Tx  output  1  registered serial line
Tx_FrameActive  output  1  high while flag, payload or abort bits are on Tx
Tx_Done  output  1  1-cycle pulse: frame closed normally
Tx_AbortedFrame  output  1  1-cycle pulse: abort sequence completed
Tx_Underrun  output  1  1-cycle pulse, coincident with the abort start, for underrun-caused aborts

Behaviour:
- Reset (Rst=0, async): Tx=1, Tx_Ready=0, Tx_FrameActive=0, all pulses 0, state IDLE. The hold register, shift register and stuff counter are cleared. A mid-frame reset drops the frame silently, with no abort pattern.
- Handshake: a byte transfers on a rising edge with Tx_Valid&&Tx_Ready.
  - Tx_Ready = TxEN && hold register empty && no Last byte captured in this frame && state in {IDLE, FLAG_OPEN, DATA}.
  - The block has a single one-byte hold register feeding an 8-bit shift register.
- States: IDLE, FLAG_OPEN, DATA, STUFF, FLAG_CLOSE, ABORT.
- IDLE: Tx=1. When a byte is accepted at cycle T, go to FLAG_OPEN.
  - Flag bits appear on Tx at T+1..T+8 as 0,1,1,1,1,1,1,0.
  - Tx_FrameActive rises at T+1.
- DATA: the first payload bit is on Tx at T+9. Bits go out LSB first, one per cycle.
  - After the 8th bit of a byte, if the hold register is full, load it into the shift register with no gap.
  - If the byte just finished was Last, go to FLAG_CLOSE.
  - Otherwise it is an underrun: go to ABORT and pulse Tx_Underrun in the first abort-bit cycle.
- STUFF: the ones counter counts consecutive payload 1s and clears on any 0 sent, including a stuffed 0.
  - When it reaches STUFF_LIMIT, the next Tx bit is an inserted 0 and the shift register does not advance.
  - Stuffing spans byte boundaries.
  - If the last payload bit completes a run of 5 ones, the stuffed 0 precedes the closing flag.
  - The counter resets at frame start. Flag and abort bits are never stuffed or counted.
- FLAG_CLOSE: 8 flag bits. In the cycle after the last flag bit the block is in IDLE with Tx=1, Tx_FrameActive=0 and a Tx_Done pulse. Tx_Ready may be high in that cycle, giving a minimum inter-frame gap of one idle bit.
- ABORT entry: on Tx_AbortReq=1 or TxEN=0 sampled while Tx_FrameActive (any state except IDLE).
  - The next Tx bit is 0, followed by ABORT_ONES ones. The in-progress byte, any stuff bit and the hold register are discarded.
  - In the cycle after the final 1: IDLE, Tx=1, Tx_FrameActive=0, Tx_AbortedFrame pulse.
  - Abort requests in IDLE or during ABORT are ignored.
- Simultaneous events:
  - Abort and normal completion in the same cycle: abort wins.
  - Abort and underrun in the same cycle: a single abort, with Tx_Underrun pulsed.
- TxEN=0 in IDLE: Tx=1 and Tx_Ready=0.

Test Plan:
- Idle: Rst released, TxEN=0 for 50 cycles, then TxEN=1 with no valid data → Tx=1 throughout, Tx_Ready=0 then 1, Tx_FrameActive=0.
- Single byte 0x00 with Last, accepted at T → Tx(T+1..T+8)=01111110, Tx(T+9..T+16)=0, closing flag at T+17..T+24, Tx_Done at T+25, FrameActive high for 24 cycles.
- Byte 0xFF with Last → payload on Tx = 1,1,1,1,1,0,1,1,1 (9 bits). Byte 0x7E → 0,1,1,1,1,1,0,1,0. Closing flag follows immediately, and the Rx FlagDetect path sees exactly 2 flags.
- Abort: 3-byte frame, Tx_AbortReq pulsed at cycle A mid-payload → Tx(A+1)=0, Tx(A+2..A+8)=1, Tx_AbortedFrame at A+9, Tx_Done never asserted. Repeat with TxEN dropped instead of Tx_AbortReq.
- Underrun: first byte 0x55 without Last, then Tx_Valid held low → after the 8th payload bit, abort 01111111, Tx_Underrun pulsed in the cycle the leading abort 0 is on Tx, Tx_AbortedFrame one cycle after the final abort 1.
- Back-to-back: two frames with Tx_Valid held high → exactly one Tx=1 idle bit between closing flag and next opening flag, and all bytes delivered in order.
